// File: rtl/lut_neuron_pkg.sv
// Shared types and helpers for the runtime-reconfigurable LUT neuron.
package lut_neuron_pkg;

    // Controller states: unconfigured, loading, draining before reload, running.
    typedef enum logic [1:0] {
        StUncfg = 2'd0,
        StLoad  = 2'd1,
        StDrain = 2'd2,
        StRun   = 2'd3
    } state_e;

    localparam int unsigned DefFanin = 4;
    localparam int unsigned DefInBw  = 2;

    // Table address width: one IN_BW-bit field per input.
    function automatic int unsigned calc_addr_w(input int unsigned fanin,
                                                input int unsigned in_bw);
        return fanin * in_bw;
    endfunction

    // Table depth: one entry per input combination.
    function automatic int unsigned calc_depth(input int unsigned fanin,
                                               input int unsigned in_bw);
        return 32'd1 << (fanin * in_bw);
    endfunction

    // Map a config stream index to a table address. Digit i of k (input 0 is the
    // least-significant digit) lands in the in_data field of input i, which sits at
    // the MSB end for input 0, so the digit order is reversed.
    function automatic logic [31:0] cfg_index_to_addr(input logic [31:0] k,
                                                      input int unsigned fanin,
                                                      input int unsigned in_bw);
        logic [31:0] addr;
        int          digit;
        int          pos;
        int          dest;
        addr = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < int'(fanin * in_bw)) begin
                digit      = b / int'(in_bw);
                pos        = b % int'(in_bw);
                dest       = (int'(fanin) - 1 - digit) * int'(in_bw) + pos;
                addr[dest] = k[b];
            end
        end
        return addr;
    endfunction

endpackage

// File: rtl/lut_neuron_cfg_stage.sv
// One elastic valid/ready register slice of the lookup pipeline.
module lut_pipe_stage #(
    parameter int unsigned DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    output logic              up_ready,
    input  logic              down_ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // Slice accepts whenever it is empty or its contents are leaving this cycle.
    always_comb begin
        up_ready = !valid || down_ready;
    end

    // Capture upstream data on advance; data only changes when a new beat enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (up_ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/lut_neuron_cfg.sv
// LogicNets neuron with a serially loadable truth table and elastic lookup pipeline.
module lut_neuron_cfg
    import lut_neuron_pkg::*;
#(
    parameter int unsigned FANIN  = DefFanin,
    parameter int unsigned IN_BW  = DefInBw,
    parameter int unsigned OUT_BW = 2,
    parameter int unsigned PIPE   = 1,
    localparam int unsigned ADDR_W = calc_addr_w(FANIN, IN_BW),
    localparam int unsigned DEPTH  = calc_depth(FANIN, IN_BW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [OUT_BW-1:0] cfg_data,
    output logic              cfg_done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_BW-1:0] out_data
);

    localparam logic [ADDR_W:0] KLast = (ADDR_W + 1)'(DEPTH - 1);

    state_e            state;
    logic [ADDR_W:0]   k;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              in_accept;
    logic [OUT_BW-1:0] ram_rd;
    logic              drain_done;

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [OUT_BW-1:0] mem [DEPTH];

    // Pipeline plumbing: index PIPE of st_ready is the downstream accept.
    logic [PIPE-1:0]   up_valid;
    logic [OUT_BW-1:0] up_data  [PIPE];
    logic [PIPE:0]     st_ready;
    logic [PIPE-1:0]   st_valid;
    logic [OUT_BW-1:0] st_data  [PIPE];
    logic [PIPE-1:0]   nxt_valid;

    assign st_ready[PIPE] = out_ready;

    for (genvar s = 0; s < PIPE; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign up_valid[s] = in_accept;
            assign up_data[s]  = ram_rd;
        end else begin : g_body
            assign up_valid[s] = st_valid[s-1];
            assign up_data[s]  = st_data[s-1];
        end

        // Valid this stage will hold after the next edge; used to leave DRAIN promptly.
        assign nxt_valid[s] = st_ready[s] ? up_valid[s] : st_valid[s];

        lut_pipe_stage #(
            .DATA_W (OUT_BW)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (up_valid[s]),
            .up_data    (up_data[s]),
            .up_ready   (st_ready[s]),
            .down_ready (st_ready[s+1]),
            .valid      (st_valid[s]),
            .data       (st_data[s])
        );
    end

    // Handshake decode; cfg_start blocks new lookups in the same cycle it reloads.
    always_comb begin
        cfg_ready  = (state == StLoad);
        in_ready   = (state == StRun) && !cfg_start && st_ready[0];
        in_accept  = in_valid && in_ready;
        out_valid  = st_valid[PIPE-1];
        out_data   = st_data[PIPE-1];
        drain_done = (nxt_valid == '0);
        // A restart pulse wins over a word offered in the same cycle.
        wr_en      = (state == StLoad) && cfg_valid && !cfg_start;
        wr_addr    = ADDR_W'(cfg_index_to_addr(32'(k), FANIN, IN_BW));
        ram_rd     = mem[in_data];
    end

    // Controller FSM with load index counter and registered done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StUncfg;
            k        <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            unique case (state)
                StUncfg: begin
                    if (cfg_start) begin
                        state <= StLoad;
                        k     <= '0;
                    end
                end
                StLoad: begin
                    if (cfg_start) begin
                        k <= '0;
                    end else if (cfg_valid) begin
                        if (k == KLast) begin
                            state    <= StRun;
                            cfg_done <= 1'b1;
                            k        <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (cfg_start) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_done) begin
                        state <= StLoad;
                        k     <= '0;
                    end
                end
                default: state <= StUncfg;
            endcase
        end
    end

    // Table write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_lut_neuron_cfg.sv
// Directed bench: default instance (PIPE=1) and a PIPE=2, FANIN=3, IN_BW=3 instance.
module tb_lut_neuron_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default instance
    logic       rst1 = 1'b1;
    logic       cfg_start1 = 0, cfg_valid1 = 0, cfg_ready1, cfg_done1;
    logic [1:0] cfg_data1 = '0;
    logic       in_valid1 = 0, in_ready1, out_valid1, out_ready1 = 0;
    logic [7:0] in_data1 = '0;
    logic [1:0] out_data1;

    // Deep-pipeline instance
    logic       rst2 = 1'b1;
    logic       cfg_start2 = 0, cfg_valid2 = 0, cfg_ready2, cfg_done2;
    logic [1:0] cfg_data2 = '0;
    logic       in_valid2 = 0, in_ready2, out_valid2, out_ready2 = 0;
    logic [8:0] in_data2 = '0;
    logic [1:0] out_data2;

    lut_neuron_cfg dut1 (
        .clk       (clk),
        .rst       (rst1),
        .cfg_start (cfg_start1),
        .cfg_valid (cfg_valid1),
        .cfg_ready (cfg_ready1),
        .cfg_data  (cfg_data1),
        .cfg_done  (cfg_done1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1)
    );

    lut_neuron_cfg #(
        .FANIN  (3),
        .IN_BW  (3),
        .OUT_BW (2),
        .PIPE   (2)
    ) dut2 (
        .clk       (clk),
        .rst       (rst2),
        .cfg_start (cfg_start2),
        .cfg_valid (cfg_valid2),
        .cfg_ready (cfg_ready2),
        .cfg_data  (cfg_data2),
        .cfg_done  (cfg_done2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2)
    );

    // Load the default instance. mode 0: entry k = (k>>2)&3, mode 1: all 2'b01.
    // restart_after != 0 sends that many 2'b11 words, then pulses cfg_start.
    task automatic load1(input bit do_start, input int mode, input int restart_after);
        int acc, guard, done_early, restarted;
        acc = 0; guard = 0; done_early = 0; restarted = 0;
        if (do_start) begin
            @(negedge clk); cfg_start1 = 1;
            @(negedge clk); cfg_start1 = 0;
            while (!cfg_ready1 && guard < 20) begin
                @(negedge clk); guard++;
            end
            n_checks++;
            if (cfg_ready1 !== 1'b1) begin
                n_fail++; $display("FAIL load_enter: cfg_ready=%b expected 1", cfg_ready1);
            end
        end
        guard = 0;
        while (acc < 256 && guard < 2000) begin
            if (restart_after != 0 && restarted == 0 && acc == restart_after) begin
                cfg_start1 = 1; cfg_valid1 = 0; restarted = 1; acc = 0;
            end else begin
                cfg_start1 = 0; cfg_valid1 = 1;
                if (mode == 1) cfg_data1 = 2'b01;
                else if (restart_after != 0 && restarted == 0) cfg_data1 = 2'b11;
                else cfg_data1 = 2'((acc >> 2) & 3);
            end
            #1;
            if (cfg_done1) done_early++;
            if (cfg_valid1 && cfg_ready1 && !cfg_start1) acc++;
            guard++;
            @(negedge clk);
        end
        cfg_valid1 = 0; cfg_start1 = 0;
        #1;
        n_checks++;
        if (acc != 256 || done_early != 0) begin
            n_fail++;
            $display("FAIL load_count: accepts=%0d early_done=%0d expected 256 and 0",
                     acc, done_early);
        end
        n_checks++;
        if (cfg_done1 !== 1'b1 || cfg_ready1 !== 1'b0 || in_ready1 !== 1'b1) begin
            n_fail++;
            $display("FAIL load_finish: done=%b cfg_ready=%b in_ready=%b expected 1 0 1",
                     cfg_done1, cfg_ready1, in_ready1);
        end
        @(negedge clk); #1;
        n_checks++;
        if (cfg_done1 !== 1'b0) begin
            n_fail++; $display("FAIL done_pulse: cfg_done=%b expected 0", cfg_done1);
        end
    endtask

    // Single lookup on the default instance with 1-cycle latency.
    task automatic lookup1(input logic [7:0] a, input logic [1:0] exp_d);
        @(negedge clk);
        out_ready1 = 1; in_valid1 = 1; in_data1 = a;
        #1;
        n_checks++;
        if (in_ready1 !== 1'b1) begin
            n_fail++; $display("FAIL lookup_ready: addr=%h in_ready=%b expected 1", a, in_ready1);
        end
        @(negedge clk);
        in_valid1 = 0;
        #1;
        n_checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== exp_d) begin
            n_fail++;
            $display("FAIL lookup: addr=%h valid=%b data=%b expected 1 %b",
                     a, out_valid1, out_data1, exp_d);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        in_valid1 = 1; in_data1 = 8'hE4;
        #1;
        n_checks++;
        if (cfg_ready1 !== 0 || cfg_done1 !== 0 || in_ready1 !== 0 || out_valid1 !== 0
            || out_data1 !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_values: cfg_ready=%b done=%b in_ready=%b ov=%b od=%b exp 0",
                     cfg_ready1, cfg_done1, in_ready1, out_valid1, out_data1);
        end
        @(negedge clk); rst1 = 0; rst2 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (in_ready1 !== 0 || out_valid1 !== 0 || cfg_ready1 !== 0) begin
                n_fail++;
                $display("FAIL uncfg_idle: in_ready=%b out_valid=%b cfg_ready=%b expected 0",
                         in_ready1, out_valid1, cfg_ready1);
            end
        end
        in_valid1 = 0;
        @(negedge clk); cfg_start1 = 1;
        @(negedge clk); cfg_start1 = 0;
        n_checks++;
        if (cfg_ready1 !== 1'b1) begin
            n_fail++; $display("FAIL cfg_ready_rise: cfg_ready=%b expected 1", cfg_ready1);
        end
    endtask

    task automatic test_load_lookup();
        load1(1'b0, 0, 0);
        lookup1(8'hE4, 2'b10);
        lookup1(8'h30, 2'b11);
        lookup1(8'hCF, 2'b00);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_q[$];
        logic [1:0] held, e;
        logic [7:0] a;
        int sent, got, stalled;
        sent = 0; got = 0; stalled = 0; held = '0;
        for (int cyc = 0; cyc < 400 && got < 64; cyc++) begin
            @(negedge clk);
            out_ready1 = (cyc % 2 == 0);
            in_valid1  = (sent < 64);
            a = 8'((sent * 37 + 11) & 8'hFF);
            in_data1 = a;
            #1;
            if (stalled != 0) begin
                n_checks++;
                if (out_valid1 !== 1'b1 || out_data1 !== held) begin
                    n_fail++;
                    $display("FAIL stall_stable: valid=%b data=%b expected 1 %b",
                             out_valid1, out_data1, held);
                end
            end
            if (in_valid1 && in_ready1) begin
                exp_q.push_back(a[5:4]);
                sent++;
            end
            if (out_valid1 && out_ready1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
                n_checks++;
                if (out_data1 !== e) begin
                    n_fail++;
                    $display("FAIL stream_data: result %0d data=%b expected %b", got, out_data1, e);
                end
                got++;
            end
            stalled = (out_valid1 && !out_ready1) ? 1 : 0;
            held = out_data1;
        end
        in_valid1 = 0;
        n_checks++;
        if (sent != 64 || got != 64 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_count: sent=%0d got=%0d pending=%0d expected 64 64 0",
                     sent, got, exp_q.size());
        end
        // Full-rate check: one result every cycle with out_ready held high.
        @(negedge clk); out_ready1 = 1; @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            in_valid1 = 1; in_data1 = 8'(i << 4);
            #1;
            if (i > 0) begin
                n_checks++;
                if (in_ready1 !== 1 || out_valid1 !== 1 || out_data1 !== 2'((i - 1) & 3)) begin
                    n_fail++;
                    $display("FAIL full_rate: i=%0d ir=%b ov=%b od=%b expected 1 1 %0d",
                             i, in_ready1, out_valid1, out_data1, (i - 1) & 3);
                end
            end
            @(negedge clk);
        end
        in_valid1 = 0;
        @(negedge clk);
    endtask

    task automatic test_reload();
        // Stalled result must survive DRAIN, and LOAD waits until it leaves.
        @(negedge clk); in_valid1 = 1; in_data1 = 8'hE4; out_ready1 = 0;
        #1;
        n_checks++;
        if (in_ready1 !== 1'b1) begin
            n_fail++; $display("FAIL drain_setup: in_ready=%b expected 1", in_ready1);
        end
        @(negedge clk); in_valid1 = 0; cfg_start1 = 1;
        @(negedge clk); cfg_start1 = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (cfg_ready1 !== 0 || out_valid1 !== 1 || out_data1 !== 2'b10) begin
                n_fail++;
                $display("FAIL drain_hold: cfg_ready=%b ov=%b od=%b expected 0 1 10",
                         cfg_ready1, out_valid1, out_data1);
            end
            @(negedge clk);
        end
        out_ready1 = 1;
        #1;
        n_checks++;
        if (cfg_ready1 !== 1'b0) begin
            n_fail++; $display("FAIL drain_early: cfg_ready=%b expected 0", cfg_ready1);
        end
        @(negedge clk); #1;
        n_checks++;
        if (cfg_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_exit: cfg_ready=%b ov=%b expected 1 0", cfg_ready1, out_valid1);
        end
        load1(1'b0, 0, 0);
        // cfg_start beats a simultaneous lookup request.
        @(negedge clk); in_valid1 = 1; in_data1 = 8'hE4; out_ready1 = 1;
        @(negedge clk); in_data1 = 8'h10; cfg_start1 = 1;
        #1;
        n_checks++;
        if (in_ready1 !== 0 || out_valid1 !== 1 || out_data1 !== 2'b10) begin
            n_fail++;
            $display("FAIL start_wins: in_ready=%b ov=%b od=%b expected 0 1 10",
                     in_ready1, out_valid1, out_data1);
        end
        @(negedge clk); cfg_start1 = 0; in_valid1 = 0;
        #1;
        n_checks++;
        if (out_valid1 !== 0 || cfg_ready1 !== 0) begin
            n_fail++;
            $display("FAIL start_no_accept: ov=%b cfg_ready=%b expected 0 0",
                     out_valid1, cfg_ready1);
        end
        @(negedge clk); #1;
        n_checks++;
        if (cfg_ready1 !== 1'b1) begin
            n_fail++; $display("FAIL reload_enter: cfg_ready=%b expected 1", cfg_ready1);
        end
        load1(1'b0, 1, 0);
        lookup1(8'hE4, 2'b01);
        lookup1(8'h00, 2'b01);
        lookup1(8'hFF, 2'b01);
    endtask

    task automatic test_restart();
        load1(1'b1, 0, 100);
        lookup1(8'hE4, 2'b10);
        lookup1(8'h1B, 2'b01);
    endtask

    task automatic test_pipe2();
        int acc, guard;
        acc = 0; guard = 0;
        @(negedge clk); cfg_start2 = 1;
        @(negedge clk); cfg_start2 = 0;
        while (acc < 512 && guard < 3000) begin
            cfg_valid2 = 1; cfg_data2 = 2'(acc & 3);
            #1;
            if (cfg_ready2) acc++;
            guard++;
            @(negedge clk);
        end
        cfg_valid2 = 0;
        #1;
        n_checks++;
        if (acc != 512 || cfg_done2 !== 1'b1 || in_ready2 !== 1'b1) begin
            n_fail++;
            $display("FAIL p2_load: accepts=%0d done=%b in_ready=%b expected 512 1 1",
                     acc, cfg_done2, in_ready2);
        end
        @(negedge clk); in_valid2 = 1; in_data2 = 9'b001000000; out_ready2 = 1;
        @(negedge clk); in_valid2 = 0;
        #1;
        n_checks++;
        if (out_valid2 !== 1'b0) begin
            n_fail++; $display("FAIL p2_latency1: out_valid=%b expected 0", out_valid2);
        end
        @(negedge clk); #1;
        n_checks++;
        if (out_valid2 !== 1'b1 || out_data2 !== 2'b01) begin
            n_fail++;
            $display("FAIL p2_lookup: ov=%b od=%b expected 1 01", out_valid2, out_data2);
        end
        // Stream, then reset mid-flight.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); in_valid2 = 1; in_data2 = 9'(((i + 2) & 3) << 6);
        end
        #1;
        n_checks++;
        if (out_valid2 !== 1'b1 || out_data2 !== 2'b11) begin
            n_fail++;
            $display("FAIL p2_stream: ov=%b od=%b expected 1 11", out_valid2, out_data2);
        end
        @(negedge clk); rst2 = 1;
        #1;
        n_checks++;
        if (out_valid2 !== 0 || out_data2 !== 0 || in_ready2 !== 0 || cfg_ready2 !== 0
            || cfg_done2 !== 0) begin
            n_fail++;
            $display("FAIL p2_reset: ov=%b od=%b ir=%b cr=%b cd=%b expected all 0",
                     out_valid2, out_data2, in_ready2, cfg_ready2, cfg_done2);
        end
        @(negedge clk); rst2 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (in_ready2 !== 0 || out_valid2 !== 0 || cfg_ready2 !== 0) begin
                n_fail++;
                $display("FAIL p2_uncfg: ir=%b ov=%b cr=%b expected 0 0 0",
                         in_ready2, out_valid2, cfg_ready2);
            end
        end
        in_valid2 = 0;
    endtask

    initial begin
        test_reset();
        test_load_lookup();
        test_back_to_back();
        test_reload();
        test_restart();
        test_pipe2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
